simd_xnor_accumulator: RTL and testbench

// - Downstream consumer of the Input_Buffer. For one neuron pass it reads synopseFold SIMD words from the buffer,

---
 rtl/simd_xnor_accumulator.sv | 133 +++++++++++++
 tb/tb_simd_xnor_accumulator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_xnor_accumulator.sv
// Binarized SIMD dot-product engine: XNOR/popcount of buffered words against weights, accumulated per level.
// Optional SIGNED_DOT_EN reports the +/-1 dot product (2*popcount - N) instead of the raw popcount.
module simd_xnor_accumulator #(
    parameter int address_width       = 12,
    parameter int synopseFold         = 18,
    parameter int simd_width          = 32,
    parameter int binary_input_levels = 2,
    localparam int ACC_W  = $clog2(simd_width*synopseFold+1),
`ifdef SIGNED_DOT_EN
    localparam int OUT_W  = ACC_W+1,
`else
    localparam int OUT_W  = ACC_W,
`endif
    localparam int FOLD_W = (synopseFold > 1) ? $clog2(synopseFold) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [address_width-1:0]                  base_addr,
    input  logic [simd_width-1:0]                     weight,
    output logic                                      buf_enable,
    output logic                                      buf_rwEn,
    output logic [address_width-1:0]                  buf_address,
    input  logic [simd_width*binary_input_levels-1:0] buf_data,
    input  logic                                      buf_ready,
    output logic [FOLD_W-1:0]                         fold_idx,
    output logic                                      busy,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [binary_input_levels*OUT_W-1:0]      out_sum
);

    typedef enum logic [1:0] {IDLE, FETCH, GAP, DONE} state_t;

    state_t                                         state_q, state_d;
    logic [FOLD_W-1:0]                              fold_q, fold_d;
    logic [address_width-1:0]                       base_q, base_d;
    logic [binary_input_levels-1:0][ACC_W-1:0]      acc_q, acc_d;
    logic [binary_input_levels-1:0][OUT_W-1:0]      sum_q, sum_d;

    function automatic logic [ACC_W-1:0] popcount(input logic [simd_width-1:0] v);
        logic [ACC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < simd_width; i++) begin
            cnt = cnt + ACC_W'(v[i]);
        end
        return cnt;
    endfunction

`ifdef SIGNED_DOT_EN
    // Each matching lane counts +1 and each mismatch -1, so dot = 2*matches - total lanes.
    function automatic logic [OUT_W-1:0] to_out(input logic [ACC_W-1:0] a);
        logic signed [OUT_W-1:0] dbl;
        logic signed [OUT_W-1:0] total;
        dbl   = signed'({a, 1'b0});
        total = signed'(OUT_W'(simd_width*synopseFold));
        return dbl - total;
    endfunction
`else
    function automatic logic [OUT_W-1:0] to_out(input logic [ACC_W-1:0] a);
        return a;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        fold_d  = fold_q;
        base_d  = base_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    fold_d  = '0;
                    acc_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (buf_ready) begin
                    for (int l = 0; l < binary_input_levels; l++) begin
                        acc_d[l] = acc_q[l] + popcount(~(buf_data[l*simd_width +: simd_width] ^ weight));
                    end
                    if (fold_q == FOLD_W'(synopseFold-1)) begin
                        // Result is formed from acc_d so the last fold is included without an extra cycle.
                        for (int l = 0; l < binary_input_levels; l++) begin
                            sum_d[l] = to_out(acc_d[l]);
                        end
                        state_d = DONE;
                    end else begin
                        fold_d  = fold_q + 1'b1;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                state_d = FETCH;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            fold_q  <= '0;
            base_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            fold_q  <= fold_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end

    assign buf_enable  = (state_q == FETCH);
    assign buf_rwEn    = 1'b1;
    assign buf_address = base_q + address_width'(fold_q);
    assign fold_idx    = fold_q;
    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_sum     = sum_q;

endmodule

// File: tb/tb_simd_xnor_accumulator.sv
// Bench for simd_xnor_accumulator: buffer responder plus a popcount reference model over a word memory.
module tb_simd_xnor_accumulator;

    localparam int AW    = 12;
    localparam int FOLD  = 18;
    localparam int SIMD  = 32;
    localparam int LVL   = 2;
    localparam int DW    = SIMD*LVL;
    localparam int ACC_W = $clog2(SIMD*FOLD+1);
`ifdef SIGNED_DOT_EN
    localparam int OUT_W = ACC_W+1;
`else
    localparam int OUT_W = ACC_W;
`endif
    localparam int FW    = $clog2(FOLD);
    localparam int SW    = LVL*OUT_W;

    logic            clk;
    logic            rst;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [SIMD-1:0] weight;
    logic            buf_enable;
    logic            buf_rwEn;
    logic [AW-1:0]   buf_address;
    logic [DW-1:0]   buf_data;
    logic            buf_ready;
    logic [FW-1:0]   fold_idx;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_sum;

    simd_xnor_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .weight(weight),
        .buf_enable(buf_enable), .buf_rwEn(buf_rwEn), .buf_address(buf_address),
        .buf_data(buf_data), .buf_ready(buf_ready), .fold_idx(fold_idx), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]   mem [4096];
    logic [SIMD-1:0] wt  [FOLD];

    int n_cmp = 0;
    int n_bad = 0;
    int delay = 1;
    int wait_cnt = 0;
    int grants = 0;
    int low_run = 0;
    int base_cur = 0;
    bit prev_en = 0;
    bit tracking = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected per-level result: matches = lanes - popcount(data ^ weight), summed over folds.
    function automatic logic [SW-1:0] ref_sum(input int base);
        logic [SW-1:0]   res;
        logic [DW-1:0]   word;
        logic [SIMD-1:0] lane;
        int s;
        int v;
        res = '0;
        for (int l = 0; l < LVL; l++) begin
            s = 0;
            for (int f = 0; f < FOLD; f++) begin
                word = mem[(base + f) % 4096];
                lane = word[l*SIMD +: SIMD];
                s += SIMD - $countones(lane ^ wt[f]);
            end
`ifdef SIGNED_DOT_EN
            v = 2*s - SIMD*FOLD;
`else
            v = s;
`endif
            res[l*OUT_W +: OUT_W] = OUT_W'(v);
        end
        return res;
    endfunction

    // One clock: advance past the edge, then play the buffer and weight memory.
    task automatic tick();
        logic [AW-1:0] exp_a;
        @(posedge clk);
        #1;
        if (tracking) begin
            if (buf_enable) begin
                exp_a = AW'(base_cur + grants);
                check("buf_address", 64'(buf_address), 64'(exp_a));
                check("fold_idx", 64'(fold_idx), 64'(grants));
                if (!prev_en && grants > 0) check("gap_len", 64'(low_run), 64'(1));
                low_run = 0;
            end else if (grants > 0 && grants < FOLD) begin
                low_run++;
            end
            prev_en = buf_enable;
        end
        if (buf_enable) begin
            wait_cnt++;
            if (wait_cnt > delay) begin
                buf_ready = 1'b1;
                buf_data  = mem[buf_address];
                weight    = wt[fold_idx];
                grants++;
            end else begin
                buf_ready = 1'b0;
                buf_data  = {$urandom, $urandom};
                weight    = $urandom;
            end
        end else begin
            wait_cnt  = 0;
            buf_ready = 1'b0;
            buf_data  = {$urandom, $urandom};
            weight    = $urandom;
        end
    endtask

    task automatic run_pass(input int base, input int dly, input bit ack, input string tag);
        int lat;
        logic [SW-1:0] exp_s;
        exp_s    = ref_sum(base);
        delay    = dly;
        grants   = 0;
        low_run  = 0;
        prev_en  = 0;
        base_cur = base;
        tracking = 1;
        start     = 1'b1;
        base_addr = AW'(base);
        tick();
        start     = 1'b0;
        base_addr = AW'($urandom);
        lat = 1;
        while (!out_valid && lat < 1000) begin
            tick();
            lat++;
        end
        tracking = 0;
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_latency"}, 64'(lat), 64'(FOLD*dly + 2*FOLD));
        check({tag, "_sum"}, 64'(out_sum), 64'(exp_s));
        check({tag, "_folds"}, 64'(grants), 64'(FOLD));
        if (ack) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check({tag, "_idle_busy"}, 64'(busy), 64'(0));
            check({tag, "_idle_valid"}, 64'(out_valid), 64'(0));
        end
    endtask

    task automatic fill(input logic [DW-1:0] d, input logic [SIMD-1:0] w);
        for (int i = 0; i < 4096; i++) mem[i] = d;
        for (int f = 0; f < FOLD; f++) wt[f] = w;
    endtask

    initial begin
        logic [SW-1:0] exp_hold;
        logic [SW-1:0] exp_t;
        int k;
        clk = 0; rst = 0; start = 0; base_addr = '0; weight = '0;
        buf_data = '0; buf_ready = 0; out_ready = 0;
        fill({DW{1'b1}}, {SIMD{1'b1}});

        tick(); tick();
        check("rst_buf_enable", 64'(buf_enable), 64'(0));
        check("rst_buf_rwEn", 64'(buf_rwEn), 64'(1));
        check("rst_buf_address", 64'(buf_address), 64'(0));
        check("rst_fold_idx", 64'(fold_idx), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_sum", 64'(out_sum), 64'(0));
        rst = 1;
        tick();

        // Test 1: all ones against all-ones weight
        run_pass(2, 1, 1, "t1");
        exp_t = {OUT_W'(576), OUT_W'(576)};
        check("t1_const", 64'(ref_sum(2)), 64'(exp_t));

        // Test 2: level 0 ones, level 1 zeros, zero weight
        fill({{SIMD{1'b0}}, {SIMD{1'b1}}}, {SIMD{1'b0}});
        run_pass(2, 1, 1, "t2");
        exp_t = {OUT_W'(576), OUT_W'(0)};
`ifdef SIGNED_DOT_EN
        exp_t = {OUT_W'(576), OUT_W'(-576)};
`endif
        check("t2_const", 64'(out_sum), 64'(exp_t));

        // Test 3: address wrap
        fill({DW{1'b1}}, {SIMD{1'b1}});
        run_pass(4095, 1, 1, "t3");

        // Test 4: slow buffer
        run_pass(2, 3, 1, "t4");

        // Random passes with varied base and buffer delay
        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
        for (int f = 0; f < FOLD; f++) wt[f] = $urandom;
        run_pass(4090, 1, 1, "rnd0");
        run_pass(int'($urandom_range(0, 4095)), int'($urandom_range(1, 3)), 1, "rnd1");
        run_pass(int'($urandom_range(0, 4095)), int'($urandom_range(1, 3)), 1, "rnd2");
        run_pass(int'($urandom_range(4080, 4095)), 2, 1, "rnd3");

        // Test 5: back-pressure with start pulses
        run_pass(100, 1, 0, "t5");
        exp_hold = ref_sum(100);
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 0);
            out_ready = 1'b0;
            tick();
            check("t5_hold_valid", 64'(out_valid), 64'(1));
            check("t5_hold_sum", 64'(out_sum), 64'(exp_hold));
        end
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        check("t5_ack_busy", 64'(busy), 64'(0));
        check("t5_ack_valid", 64'(out_valid), 64'(0));
        tick();
        check("t5_start_ignored", 64'(busy), 64'(0));

        // Test 6: reset during fold 7, then a clean pass
        fill({DW{1'b1}}, {SIMD{1'b1}});
        delay = 1;
        start = 1'b1;
        base_addr = AW'(2);
        tick();
        start = 1'b0;
        k = 0;
        while (fold_idx != FW'(7) && k < 200) begin
            tick();
            k++;
        end
        check("t6_fold7", 64'(fold_idx), 64'(7));
        rst = 0;
        tick();
        check("t6_buf_enable", 64'(buf_enable), 64'(0));
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_out_valid", 64'(out_valid), 64'(0));
        check("t6_out_sum", 64'(out_sum), 64'(0));
        check("t6_fold_idx", 64'(fold_idx), 64'(0));
        check("t6_buf_address", 64'(buf_address), 64'(0));
        check("t6_buf_rwEn", 64'(buf_rwEn), 64'(1));
        rst = 1;
        tick();
        run_pass(2, 1, 1, "t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
